// File: rtl/tcdm_burst_initiator.sv
// tcdm_burst_initiator
//   Initiator-side TCDM port engine. Accepts one burst command (base, length,
//   direction) and issues it as single-word TCDM requests. Read bursts are
//   issued only when a FIFO slot is reserved for the response. The response
//   arrives a fixed one cycle after grant and is returned on a valid/ready
//   stream. Write bursts take their data and byte enables from a valid/ready
//   stream.
//
// Optional feature macro: TCDM_BURST_INITIATOR_PERF_EN
//   Defined     : perf_stall_o counts cycles with tcdm_req_o & !tcdm_gnt_i.
//                 The counter saturates at 2^32-1 and clears on command
//                 acceptance.
//   Not defined : perf_stall_o is tied to 0.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o            command handshake (ready only in IDLE)
//   cmd_addr_i, cmd_len_i, cmd_write_i byte base address, word count, 1=write
//   wdata_valid_i/wdata_ready_o        write stream handshake
//   wdata_i, wbe_i                     write data and byte enables
//   rdata_valid_o/rdata_ready_i        read stream handshake
//   rdata_o                            read data (FIFO head)
//   busy_o, done_o                     FSM not IDLE, 1-cycle completion pulse
//   tcdm_req_o, tcdm_add_o, tcdm_wen_o TCDM request, byte address, 1=read
//   tcdm_be_o, tcdm_data_o             TCDM byte enables, write data
//   tcdm_gnt_i, tcdm_r_data_i          TCDM grant, read data (1 cycle after grant)
//   perf_stall_o                       grant-stall cycle counter
module tcdm_burst_initiator #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 cmd_write_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   wbe_i,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  output logic [AddrWidth-1:0] tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [BeWidth-1:0]   tcdm_be_o,
  output logic [DataWidth-1:0] tcdm_data_o,
  input  logic                 tcdm_gnt_i,
  input  logic [DataWidth-1:0] tcdm_r_data_i,
  output logic [31:0]          perf_stall_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned CrdW = CntW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e               r_state, w_state_nxt;
  logic [AddrWidth-1:0] r_addr;
  logic [LenWidth-1:0]  r_left;
  logic                 r_write;
  logic                 r_done;
  logic                 r_inflight;

  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]      r_wptr, r_rptr;
  logic [CntW-1:0]      r_count;

  logic w_accept, w_credit, w_req, w_gnt_beat, w_last;
  logic w_push, w_pop, w_empty, w_drain_done;

  assign w_accept   = cmd_valid_i && (r_state == S_IDLE);
  assign w_empty    = (r_count == '0);
  // A read may only be issued when a FIFO slot is free for its response,
  // counting the response still on its way back.
  assign w_credit   = (CrdW'(r_count) + CrdW'(r_inflight)) < CrdW'(FifoDepth);
  assign w_gnt_beat = w_req && tcdm_gnt_i;
  assign w_last     = (r_left == LenWidth'(1));
  assign w_push     = r_inflight;
  assign w_pop      = !w_empty && rdata_ready_i;

  // Next-state and request generation; request never looks at the grant.
  always_comb begin
    w_state_nxt  = r_state;
    w_req        = 1'b0;
    w_drain_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && (cmd_len_i != '0)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_req = r_write ? wdata_valid_i : w_credit;
        if (w_req && tcdm_gnt_i && w_last) w_state_nxt = r_write ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        w_drain_done = !r_inflight && w_empty;
        if (w_drain_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: command latch, beat counter, address walk, response tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_left     <= '0;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= (w_accept && (cmd_len_i == '0)) || (w_gnt_beat && r_write && w_last);
      r_inflight <= w_gnt_beat && !r_write;
      if (w_accept) begin
        r_addr  <= cmd_addr_i & ~AddrWidth'(BeWidth - 1);
        r_left  <= cmd_len_i;
        r_write <= cmd_write_i;
      end else if (w_gnt_beat) begin
        r_addr <= r_addr + AddrWidth'(BeWidth);
        r_left <= r_left - LenWidth'(1);
      end
    end
  end

  // Read-response FIFO: pointers reset, storage does not.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= tcdm_r_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && !w_pop && (r_count == CntW'(FifoDepth))));

`ifdef TCDM_BURST_INITIATOR_PERF_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= '0;
    end else if (w_accept) begin
      r_stall <= '0;
    end else if (w_req && !tcdm_gnt_i && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end
  assign perf_stall_o = r_stall;
`else
  assign perf_stall_o = '0;
`endif

  // Outputs are forced to zero whenever no request is pending.
  assign cmd_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done || w_drain_done;
  assign tcdm_req_o    = w_req;
  assign tcdm_add_o    = w_req ? r_addr : '0;
  assign tcdm_wen_o    = w_req && !r_write;
  assign tcdm_be_o     = !w_req ? '0 : (r_write ? wbe_i : '1);
  assign tcdm_data_o   = (w_req && r_write) ? wdata_i : '0;
  assign wdata_ready_o = w_gnt_beat && r_write;
  assign rdata_valid_o = !w_empty;
  assign rdata_o       = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_tcdm_burst_initiator.sv
// Directed bench for tcdm_burst_initiator (default parameters). A one-cycle
// TCDM responder returns resp(addr) for every granted read. Inputs change on
// the falling clock edge and outputs are examined 1 time unit later.
module tb_tcdm_burst_initiator;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic        busy, done;
  logic        tcdm_req, tcdm_wen, tcdm_gnt;
  logic [31:0] tcdm_add, tcdm_data, tcdm_r_data;
  logic [3:0]  tcdm_be;
  logic [31:0] perf_stall;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] g_add[$], g_data[$], rd[$];
  logic [3:0]  g_be[$];
  logic        g_wen[$];
  int          g_it[$], rd_it[$];
  bit          done_seen, stable_ok;
  int          done_it, pre_gnt, stall_cnt;
  logic        pre_req;

  always #5 clk = ~clk;

  tcdm_burst_initiator dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_write_i(cmd_write),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .wdata_i(wdata), .wbe_i(wbe),
    .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
    .busy_o(busy), .done_o(done),
    .tcdm_req_o(tcdm_req), .tcdm_add_o(tcdm_add), .tcdm_wen_o(tcdm_wen),
    .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_data),
    .tcdm_gnt_i(tcdm_gnt), .tcdm_r_data_i(tcdm_r_data),
    .perf_stall_o(perf_stall)
  );

  function automatic logic [31:0] resp(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [3:0] be_pat(input int i);
    case (i % 4)
      0:       return 4'hF;
      1:       return 4'h3;
      2:       return 4'hC;
      default: return 4'h5;
    endcase
  endfunction

  always_ff @(posedge clk)
    tcdm_r_data <= (tcdm_req && tcdm_gnt && tcdm_wen) ? resp(tcdm_add) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one command, then plays the stream/responder side cycle by cycle.
  // Iteration 0 is the first cycle after acceptance. stall_beat: grant index
  // whose grant is withheld for 3 requesting cycles. ready_at: first iteration
  // with rdata_ready high. abort_at: iteration at which reset is asserted.
  task automatic run_burst(input logic [31:0] addr, input logic [15:0] len, input logic wr,
                           input int stall_beat, input int ready_at, input int abort_at);
    int          wi;
    bit          adv;
    logic [31:0] hold_add, hold_data;
    g_add.delete(); g_data.delete(); g_be.delete(); g_wen.delete(); g_it.delete();
    rd.delete(); rd_it.delete();
    done_seen = 0; stable_ok = 1; done_it = -1; pre_gnt = -1; pre_req = 1'bx;
    stall_cnt = 0; wi = 0; adv = 0; hold_add = '0; hold_data = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_write = wr;
    wdata_valid = wr; wdata = 32'hD000_0000; wbe = be_pat(0);
    rdata_ready = (ready_at <= 0);
    #1;
    chk("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    for (int it = 0; it < 80 && !done_seen; it++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (it == abort_at) begin
        rst_ni = 1'b0;
        return;
      end
      if (adv) begin wi++; adv = 0; end
      wdata = 32'hD000_0000 + 32'(wi);
      wbe = be_pat(wi);
      tcdm_gnt = !(g_add.size() == stall_beat && stall_cnt < 3);
      rdata_ready = (it >= ready_at);
      #1;
      if (tcdm_req && !tcdm_gnt) begin
        if (stall_cnt == 0) begin
          hold_add = tcdm_add; hold_data = tcdm_data;
        end else if (tcdm_add !== hold_add || tcdm_data !== hold_data) begin
          stable_ok = 0;
        end
        stall_cnt++;
      end
      if (tcdm_req && tcdm_gnt) begin
        g_add.push_back(tcdm_add); g_data.push_back(tcdm_data);
        g_be.push_back(tcdm_be); g_wen.push_back(tcdm_wen); g_it.push_back(it);
      end
      if (it == ready_at - 1) begin pre_gnt = g_add.size(); pre_req = tcdm_req; end
      if (wdata_ready) adv = 1;
      if (rdata_valid && rdata_ready) begin rd.push_back(rdata); rd_it.push_back(it); end
      if (done) begin done_seen = 1; done_it = it; end
    end
    wdata_valid = 1'b0; tcdm_gnt = 1'b1; rdata_ready = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_write = 1'b0;
    wdata_valid = 1'b0; wdata = '0; wbe = '0; rdata_ready = 1'b1; tcdm_gnt = 1'b1;

    // Reset values
    @(negedge clk); #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(tcdm_req), 32'd0);
    chk("rst_add", tcdm_add, 32'd0);
    chk("rst_rvalid", 32'(rdata_valid), 32'd0);
    chk("rst_perf", perf_stall, 32'd0);
    @(negedge clk); rst_ni = 1'b1;

    // Read len=4 @0x100, full rate
    run_burst(32'h100, 16'd4, 1'b0, -1, 0, -1);
    chk("rd4_ngnt", 32'(g_add.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd4_add%0d", i), g_add[i], 32'h100 + 32'(4 * i));
      chk($sformatf("rd4_git%0d", i), 32'(g_it[i]), 32'(i));
      chk($sformatf("rd4_data%0d", i), rd[i], resp(32'h100 + 32'(4 * i)));
    end
    chk("rd4_wen", 32'(g_wen[0]), 32'd1);
    chk("rd4_be", 32'(g_be[0]), 32'hF);
    chk("rd4_last_rd_it", 32'(rd_it[3]), 32'd5);
    chk("rd4_done_it", 32'(done_it), 32'd6);

    // Write len=3 @0x203 (low bits dropped)
    run_burst(32'h203, 16'd3, 1'b1, -1, 0, -1);
    chk("wr3_ngnt", 32'(g_add.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wr3_add%0d", i), g_add[i], 32'h200 + 32'(4 * i));
      chk($sformatf("wr3_data%0d", i), g_data[i], 32'hD000_0000 + 32'(i));
      chk($sformatf("wr3_be%0d", i), 32'(g_be[i]), 32'(be_pat(i)));
      chk($sformatf("wr3_wen%0d", i), 32'(g_wen[i]), 32'd0);
    end
    chk("wr3_done_it", 32'(done_it), 32'd3);

    // Read len=8 @0x400 with rdata_ready low until iteration 8
    run_burst(32'h400, 16'd8, 1'b0, -1, 8, -1);
    chk("rd8_gnt_before_ready", 32'(pre_gnt), 32'd4);
    chk("rd8_req_before_ready", 32'(pre_req), 32'd0);
    chk("rd8_nrd", 32'(rd.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rd8_data%0d", i), rd[i], resp(32'h400 + 32'(4 * i)));
    chk("rd8_done", 32'(done_seen), 32'd1);

    // Write len=4 @0x300, grant withheld 3 cycles on beat 2
    run_burst(32'h300, 16'd4, 1'b1, 2, 0, -1);
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
    chk("stall_stable", 32'(stable_ok), 32'd1);
    chk("stall_add2", g_add[2], 32'h308);
    chk("stall_data2", g_data[2], 32'hD000_0002);
    chk("stall_git2", 32'(g_it[2]), 32'd5);
    chk("stall_done_it", 32'(done_it), 32'd7);
`ifdef TCDM_BURST_INITIATOR_PERF_EN
    chk("perf_after_stall", perf_stall, 32'd3);
`else
    chk("perf_after_stall", perf_stall, 32'd0);
`endif

    // Empty burst
    run_burst(32'h600, 16'd0, 1'b0, -1, 0, -1);
    chk("len0_ngnt", 32'(g_add.size()), 32'd0);
    chk("len0_done_it", 32'(done_it), 32'd0);
    @(negedge clk); #1;
    chk("len0_done_pulse_end", 32'(done), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);

    // Address wrap
    run_burst(32'hFFFF_FFFC, 16'd2, 1'b0, -1, 0, -1);
    chk("wrap_add0", g_add[0], 32'hFFFF_FFFC);
    chk("wrap_add1", g_add[1], 32'h0000_0000);
    chk("wrap_data1", rd[1], resp(32'h0));
    chk("wrap_perf_cleared", perf_stall, 32'd0);

    // Reset in the middle of a read burst
    run_burst(32'h800, 16'd8, 1'b0, -1, 100, 3);
    #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req", 32'(tcdm_req), 32'd0);
    chk("abort_rvalid", 32'(rdata_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_no_done_before", 32'(done_seen), 32'd0);
    @(negedge clk); rst_ni = 1'b1; rdata_ready = 1'b1; tcdm_gnt = 1'b1;
    run_burst(32'h500, 16'd2, 1'b1, -1, 0, -1);
    chk("post_rst_add0", g_add[0], 32'h500);
    chk("post_rst_add1", g_add[1], 32'h504);
    chk("post_rst_done_it", 32'(done_it), 32'd2);
    #1;
    chk("post_rst_rvalid", 32'(rdata_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
